// File: rtl/control_sequencer.sv
// Instruction control sequencer: fetch / execute / memory-wait / halt.
// Gates the format decoder's raw enables and tracks retired instructions.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  input  logic             ram_ready,
  input  logic             dec_reg_w,
  input  logic             dec_ram_w,
  input  logic             dec_status_load,
  input  logic             dec_mem_access,
  input  logic [1:0]       dec_ns,
  output logic [1:0]       state,
  output logic [31:0]      ir,
  output logic             fetch_req,
  output logic             reg_w_en,
  output logic             ram_w_en,
  output logic             status_load_en,
  output logic             pc_advance,
  output logic             bus_error,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    MEM   = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       load_ir, retire, set_err;

  assign state = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      timer_q       <= '0;
      ir            <= '0;
      bus_error     <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (load_ir) ir <= instr_in;
      if (set_err) bus_error <= 1'b1;
      if (retire)  retired_count <= retired_count + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    load_ir        = 1'b0;
    retire         = 1'b0;
    set_err        = 1'b0;
    fetch_req      = 1'b0;
    reg_w_en       = 1'b0;
    ram_w_en       = 1'b0;
    status_load_en = 1'b0;
    pc_advance     = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          load_ir = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Halt opcode takes priority over whatever the decoder requests.
        if (ir[31:21] == 11'h7FF) begin
          state_d = HALT;
        end else if (dec_mem_access) begin
          timer_d = '0;
          state_d = MEM;
        end else begin
          reg_w_en       = dec_reg_w;
          status_load_en = dec_status_load;
          if (dec_ns != 2'b01) begin
            pc_advance = 1'b1;
            retire     = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      MEM: begin
        ram_w_en = dec_ram_w;
        // A ready on the final allowed cycle still completes normally.
        if (ram_ready) begin
          reg_w_en   = dec_reg_w;
          pc_advance = 1'b1;
          retire     = 1'b1;
          state_d    = FETCH;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_q == TIMEOUT_LAST) begin
            set_err = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a cycle-level reference model
// compared every cycle, plus hand-computed scenario checks.
module tb_control_sequencer;
  localparam int MT = 15;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   instr_in = '0;
  logic          instr_valid = 1'b0;
  logic          ram_ready = 1'b0;
  logic          dec_reg_w = 1'b0, dec_ram_w = 1'b0, dec_status_load = 1'b0, dec_mem_access = 1'b0;
  logic [1:0]    dec_ns = 2'b00;
  logic [1:0]    state;
  logic [31:0]   ir;
  logic          fetch_req, reg_w_en, ram_w_en, status_load_en, pc_advance, bus_error;
  logic [CW-1:0] retired_count;

  int total = 0;
  int bad   = 0;

  control_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .ram_ready(ram_ready), .dec_reg_w(dec_reg_w), .dec_ram_w(dec_ram_w),
    .dec_status_load(dec_status_load), .dec_mem_access(dec_mem_access), .dec_ns(dec_ns),
    .state(state), .ir(ir), .fetch_req(fetch_req), .reg_w_en(reg_w_en), .ram_w_en(ram_w_en),
    .status_load_en(status_load_en), .pc_advance(pc_advance), .bus_error(bus_error),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=fetch 1=exec 2=mem 3=halt; mem_waits counts
  // unanswered memory cycles of the current access.
  int            m_phase;
  logic [31:0]   m_ir;
  logic          m_err;
  logic [CW-1:0] m_cnt;
  int            m_waits;

  function automatic bit is_halt_op(input logic [31:0] w);
    return w[31:21] == 11'h7FF;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_ir = '0; m_err = 1'b0; m_cnt = '0; m_waits = 0;
    end else begin
      case (m_phase)
        0: if (instr_valid) begin m_ir = instr_in; m_phase = 1; end
        1: begin
          if (is_halt_op(m_ir)) m_phase = 3;
          else if (dec_mem_access) begin m_waits = 0; m_phase = 2; end
          else if (dec_ns != 2'b01) begin m_cnt = m_cnt + 1'b1; m_phase = 0; end
        end
        2: begin
          if (ram_ready) begin m_cnt = m_cnt + 1'b1; m_phase = 0; end
          else begin
            m_waits = m_waits + 1;
            if (m_waits == MT) begin m_err = 1'b1; m_phase = 3; end
          end
        end
        default: m_phase = 3;
      endcase
    end
  end

  always @(negedge clock) begin
    bit in_exec_work, in_mem;
    in_exec_work = (m_phase == 1) && !is_halt_op(m_ir) && !dec_mem_access;
    in_mem       = (m_phase == 2);
    chk("state", 32'(state), 32'(m_phase));
    chk("ir", ir, m_ir);
    chk("fetch_req", 32'(fetch_req), 32'(m_phase == 0));
    chk("reg_w_en", 32'(reg_w_en),
        32'((in_exec_work && dec_reg_w) || (in_mem && ram_ready && dec_reg_w)));
    chk("ram_w_en", 32'(ram_w_en), 32'(in_mem && dec_ram_w));
    chk("status_load_en", 32'(status_load_en), 32'(in_exec_work && dec_status_load));
    chk("pc_advance", 32'(pc_advance),
        32'((in_exec_work && dec_ns != 2'b01) || (in_mem && ram_ready)));
    chk("bus_error", 32'(bus_error), 32'(m_err));
    chk("retired_count", 32'(retired_count), 32'(m_cnt));
  end

  int a_reg, a_ram, a_pc, a_fetch, a_exec, a_mem;

  task automatic clr();
    a_reg = 0; a_ram = 0; a_pc = 0; a_fetch = 0; a_exec = 0; a_mem = 0;
  endtask

  task automatic cycle();
    @(negedge clock);
    a_reg += int'(reg_w_en); a_ram += int'(ram_w_en); a_pc += int'(pc_advance);
    a_fetch += int'(fetch_req); a_exec += int'(state == 2'b01); a_mem += int'(state == 2'b10);
    @(posedge clock); #1;
  endtask

  task automatic do_fetch(input logic [31:0] w);
    instr_in = w; instr_valid = 1'b1;
    cycle();
    instr_valid = 1'b0;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fetch_req", 32'(fetch_req), 32'd1);
    chk("rst_state", 32'(state), 32'd0);
    reset = 1'b1;

    // Simple register instruction
    dec_reg_w = 1'b1; dec_ns = 2'b00;
    do_fetch(32'h8B000020);
    chk("t1_exec", 32'(state), 32'd1);
    chk("t1_ir", ir, 32'h8B000020);
    clr(); cycle();
    chk("t1_reg", 32'(a_reg), 32'd1);
    chk("t1_pc", 32'(a_pc), 32'd1);
    chk("t1_cnt", 32'(retired_count), 32'd1);
    chk("t1_state", 32'(state), 32'd0);

    // Load: three wait cycles, ready on the fourth
    dec_mem_access = 1'b1;
    do_fetch(32'h00000001);
    clr(); cycle();
    repeat (3) cycle();
    ram_ready = 1'b1; cycle(); ram_ready = 1'b0;
    chk("t2_mem_cycles", 32'(a_mem), 32'd4);
    chk("t2_reg", 32'(a_reg), 32'd1);
    chk("t2_cnt", 32'(retired_count), 32'd2);
    chk("t2_err", 32'(bus_error), 32'd0);

    // Multi-pass instruction
    dec_mem_access = 1'b0; dec_ns = 2'b01; dec_status_load = 1'b1;
    do_fetch(32'h12345678);
    clr(); cycle(); cycle();
    dec_ns = 2'b00; cycle(); dec_status_load = 1'b0;
    chk("t3_exec_cycles", 32'(a_exec), 32'd3);
    chk("t3_pc", 32'(a_pc), 32'd1);
    chk("t3_cnt", 32'(retired_count), 32'd3);

    // Counter wrap (4-bit counter)
    for (int i = 0; i < 12; i++) begin do_fetch(32'h00000100 + 32'(i)); cycle(); end
    chk("wrap_pre", 32'(retired_count), 32'd15);
    do_fetch(32'h00000200); cycle();
    chk("wrap_zero", 32'(retired_count), 32'd0);

    // Halt opcode; instr_valid pulses ignored
    do_fetch(32'hFFE00000);
    chk("t4_exec", 32'(state), 32'd1);
    cycle();
    chk("t4_halt", 32'(state), 32'd3);
    clr();
    for (int i = 0; i < 4; i++) begin instr_valid = i[0]; cycle(); end
    instr_valid = 1'b0;
    chk("t4_no_fetch", 32'(a_fetch), 32'd0);
    chk("t4_still_halt", 32'(state), 32'd3);
    chk("t4_cnt", 32'(retired_count), 32'd0);
    reset = 1'b0; cycle(); reset = 1'b1;

    // Reset during the third memory wait cycle of a store
    dec_mem_access = 1'b1; dec_ram_w = 1'b1; dec_reg_w = 1'b1;
    do_fetch(32'h00000003);
    cycle(); cycle(); cycle();
    chk("t5_in_mem", 32'(state), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_ram_w", 32'(ram_w_en), 32'd0);
    chk("t5_reg_w", 32'(reg_w_en), 32'd0);
    chk("t5_fetch_req", 32'(fetch_req), 32'd1);
    chk("t5_err", 32'(bus_error), 32'd0);
    cycle(); reset = 1'b1;
    dec_mem_access = 1'b0; dec_ram_w = 1'b0;
    do_fetch(32'h00000004);
    chk("t5_resume", 32'(state), 32'd1);
    cycle();
    chk("t5_cnt", 32'(retired_count), 32'd1);

    // Store with ready on the last allowed cycle
    dec_mem_access = 1'b1; dec_ram_w = 1'b1; dec_reg_w = 1'b0;
    do_fetch(32'h00000005);
    clr(); cycle();
    repeat (MT - 1) cycle();
    ram_ready = 1'b1; cycle(); ram_ready = 1'b0;
    chk("t6_ram_w", 32'(a_ram), 32'd15);
    chk("t6_err", 32'(bus_error), 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_cnt", 32'(retired_count), 32'd2);

    // Store that never completes
    do_fetch(32'h00000006);
    clr(); cycle();
    repeat (MT) cycle();
    chk("t7_ram_w", 32'(a_ram), 32'd15);
    chk("t7_mem_cycles", 32'(a_mem), 32'd15);
    chk("t7_err", 32'(bus_error), 32'd1);
    chk("t7_state", 32'(state), 32'd3);
    chk("t7_cnt", 32'(retired_count), 32'd2);
    ram_ready = 1'b1; cycle(); cycle(); ram_ready = 1'b0;
    chk("t7_sticky", 32'(bus_error), 32'd1);
    chk("t7_halt", 32'(state), 32'd3);
    reset = 1'b0; #1;
    chk("t7_err_clr", 32'(bus_error), 32'd0);
    cycle(); reset = 1'b1;
    dec_mem_access = 1'b0; dec_ram_w = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum MEM-state cycles waiting for ram_ready before bus error (range 1..255).
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instr_in  input  32  instruction word from instruction memory.
REQ-006 instr_valid  input  1  instr_in valid this cycle (fetch handshake).
REQ-007 ram_ready  input  1  data RAM completes the current access this cycle.
REQ-008 dec_reg_w, dec_ram_w, dec_status_load, dec_mem_access  input  1 each  raw enables from the format decoder selected by ir.
REQ-009 dec_ns  input  2  next-state request from the selected decoder.
REQ-010 state  output  2  current state, fed to every format decoder.
REQ-011 ir  output  32  instruction register.
REQ-012 fetch_req  output  1  instruction fetch request.
REQ-013 reg_w_en, ram_w_en, status_load_en  output  1 each  gated write enables to the register file, RAM and status register.
REQ-014 pc_advance  output  1  one-cycle PC advance strobe.
REQ-015 bus_error  output  1  sticky RAM-timeout flag.
REQ-016 retired_count  output  CNT_W  count of completed instructions.

Function
REQ-017 State encoding SHALL be FETCH=00, EXEC=01, MEM=10, HALT=11.
REQ-018 state, ir, bus_error, retired_count and the wait timer SHALL be registers; fetch_req and all enables/strobes SHALL be combinational from state, timer and inputs.
REQ-019 FETCH: fetch_req=1, all enables 0; on instr_valid=1, ir<=instr_in, next state EXEC; otherwise remain in FETCH.
REQ-020 EXEC with ir[31:21]==11'h7FF (halt opcode): all enables 0, next state HALT, retired_count unchanged.
REQ-021 EXEC with dec_mem_access=1: all enables 0, wait timer cleared to 0, next state MEM.
REQ-022 EXEC otherwise: reg_w_en=dec_reg_w, status_load_en=dec_status_load, ram_w_en=0.
REQ-023 EXEC, non-memory, dec_ns==01: remain in EXEC (multi-pass instruction), pc_advance=0, retired_count unchanged.
REQ-024 EXEC, non-memory, dec_ns any other value: pc_advance=1, retired_count+1, next state FETCH.
REQ-025 MEM: ram_w_en=dec_ram_w held every MEM cycle; status_load_en=0.
REQ-026 MEM with ram_ready=1: reg_w_en=dec_reg_w, pc_advance=1, retired_count+1, next state FETCH.
REQ-027 MEM with ram_ready=0: reg_w_en=0; timer+1; when timer equals MEM_TIMEOUT-1 in this cycle, bus_error<=1 and next state HALT.
REQ-028 ram_ready=1 on the timeout cycle SHALL win: normal completion, no bus_error.
REQ-029 HALT: fetch_req=0, all enables and pc_advance 0; remain in HALT until reset.
REQ-030 retired_count SHALL wrap from all-ones to 0 without side effects.
REQ-031 bus_error SHALL be cleared only by reset.
REQ-032 instr_valid outside FETCH and ram_ready outside MEM SHALL be ignored.

Reset
REQ-033 reset=0 SHALL immediately (asynchronously) force state=FETCH, ir=0, bus_error=0, retired_count=0, timer=0.
REQ-034 During reset all combinational enables and pc_advance SHALL be 0; fetch_req SHALL be 1 (FETCH).
REQ-035 Reset asserted mid-MEM or mid-EXEC SHALL abort the instruction with no partial enable after assertion; first cycle after release is FETCH.

Verification
REQ-036 Reset release, instr_valid=1 with instr_in=32'h8B000020, dec_reg_w=1, dec_ns=00 -> EXEC next cycle, reg_w_en=1, pc_advance=1, retired_count=1, back in FETCH.
REQ-037 Load: dec_mem_access=1, dec_reg_w=1, ram_ready after 3 wait cycles -> MEM for 4 cycles, reg_w_en=1 only in the ready cycle, retired_count+1, no bus_error.
REQ-038 Store with ram_ready never asserted, MEM_TIMEOUT=15 -> ram_w_en=1 for 15 MEM cycles, then bus_error=1, state=HALT, retired_count unchanged.
REQ-039 instr_in=32'hFFE00000 -> EXEC then HALT; fetch_req stays 0 despite instr_valid pulses until reset.
REQ-040 dec_ns=01 for two EXEC cycles then 00 -> three EXEC cycles, single pc_advance, retired_count+1; retired_count preset near all-ones wraps to 0.
REQ-041 reset pulsed low during MEM wait cycle 2 -> all outputs at reset values within the same cycle, bus_error=0, normal fetch resumes.
